// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings for the ARM control unit (op/cmd, ALU and ImmSrc codes, conditions, FSM states)
package arm_ctrl_pkg;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100, CMD_MOV = 4'b1101;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;
  typedef enum logic {EXEC, WAIT} state_t;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates the ARM condition field against registered NZCV
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v, ge;
  assign {n, z, c, v} = flags;
  assign ge = n == v;
  always_comb
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = z | ~ge;
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
endmodule

// File: rtl/arm_control_unit.sv
// arm_control_unit: single-cycle ARM decode, memory-stall FSM and NZCV register (COND_EXEC_EN enables condition codes)
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        MOVInstr,
  output logic        link,
  output logic        MemWrite,
  output logic        MemReq,
  output logic        Stall,
  output logic [3:0]  Flags
);
  logic [3:0] cmd;
  logic is_dp, is_mem, is_br, is_cmp, dp_ok, ldr, cond_ex, exec, unused;
  logic [1:0] dp_alu;
  state_t state;
  assign cmd = Instr[24:21];
  assign is_dp = Instr[27:26] == OP_DP;
  assign is_mem = Instr[27:26] == OP_MEM;
  assign is_br = Instr[27:26] == OP_BR;
  assign is_cmp = cmd == CMD_CMP;
  assign ldr = is_mem & Instr[20];
  assign dp_ok = is_dp & (cmd == CMD_AND | cmd == CMD_SUB | cmd == CMD_ADD | is_cmp | cmd == CMD_ORR | cmd == CMD_MOV);
  assign dp_alu = cmd == CMD_AND ? ALU_AND : (cmd == CMD_SUB | is_cmp) ? ALU_SUB : cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
`ifdef COND_EXEC_EN
  cond_check u_cond (.cond(Instr[31:28]), .flags(Flags), .cond_ex(cond_ex));
  assign unused = ^{Instr[22], Instr[19:16], Instr[11:0]};
`else
  assign cond_ex = 1'b1;
  assign Flags = 4'b0;
  assign unused = ^{Instr[31:28], Instr[22], Instr[19:16], Instr[11:0], ALUFlags};
`endif
  assign exec = cond_ex & ~reset;
  assign RegSrc = is_br ? 2'b01 : (is_mem & ~Instr[20]) ? 2'b10 : 2'b00;
  assign ImmSrc = is_mem ? IMM_MEM : is_br ? IMM_BR : IMM_DP;
  assign ALUSrc = is_dp ? Instr[25] : (is_mem | is_br);
  assign ALUControl = is_mem ? (Instr[23] ? ALU_ADD : ALU_SUB) : is_dp ? dp_alu : ALU_ADD;
  assign MemtoReg = ldr;
  assign MOVInstr = is_dp & cmd == CMD_MOV;
  // a pending access keeps requesting until acknowledged; reset abandons it
  assign MemReq = ~reset & (state == WAIT | (is_mem & cond_ex));
  assign Stall = MemReq & ~mem_ready;
  assign RegWrite = exec & ((dp_ok & ~is_cmp) | (ldr & mem_ready) | (is_br & Instr[24]));
  assign MemWrite = exec & is_mem & ~Instr[20] & mem_ready;
  assign link = exec & is_br & Instr[24];
  assign PCSrc = (exec & is_br) | (~is_br & Instr[15:12] == 4'hF & RegWrite);
  always_ff @(posedge CLK) begin
    state <= (~reset & Stall) ? WAIT : EXEC;
`ifdef COND_EXEC_EN
    if (reset) Flags <= 4'b0;
    else if (exec & dp_ok & (Instr[20] | is_cmp))
      Flags <= {ALUFlags[3:2], (cmd == CMD_ADD | cmd == CMD_SUB | is_cmp) ? ALUFlags[1:0] : Flags[1:0]};
`endif
  end
endmodule
